// File: rtl/dl_pingpong_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// dl_pingpong_buf_ctrl_if
// Framed word stream (valid/ready/data/last) used for both the decoder-side
// input and the consumer-side output of the downlink ping-pong controller.
//   valid  word valid (driven by master)
//   ready  word accepted (driven by slave)
//   data   DW-bit word (driven by master)
//   last   final word of a frame (driven by master)
// ---------------------------------------------------------------------------
interface dl_pingpong_buf_ctrl_if #(
    parameter int DW = 10
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/dl_pingpong_buf_ctrl.sv
// ---------------------------------------------------------------------------
// dl_pingpong_buf_ctrl
// Ping-pong frame controller for the 128x10 downlink dual-port RAM. Incoming
// frames are written alternately into bank0 (0..63) and bank1 (64..127); each
// committed frame is replayed in arrival order through a 2-entry output FIFO.
// Frames longer than BANK_D words are truncated and flagged with ovf_err_o.
//
// State table
//   W_FILL | writing words of the current frame into bank wbank
//   W_DROP | frame overflowed; discarding words up to and including s_last
//   R_IDLE | waiting for bank rbank to hold a committed frame
//   R_RUN  | issuing RAM reads for bank rbank, then releasing it
//
// Ports
//   clk          system clock (also the RAM read and write clock)
//   rst_n        asynchronous active-low reset
//   s_if         input stream (slave)
//   m_if         output stream (master)
//   ram_waddr_o  RAM write address      ram_wdata_o  RAM write data
//   ram_wen_o    RAM write enable       ram_raddr_o  RAM read address
//   ram_rden_o   RAM read enable        ram_rdata_i  RAM read data (1-cycle)
//   bank_full_o  per-bank committed-frame flags
//   ovf_err_o    1-cycle pulse on truncation of an oversized frame
// ---------------------------------------------------------------------------
module dl_pingpong_buf_ctrl #(
    parameter int DW     = 10,
    parameter int AW     = 7,
    parameter int BANK_D = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dl_pingpong_buf_ctrl_if.slave  s_if,
    dl_pingpong_buf_ctrl_if.master m_if,
    output logic [AW-1:0]          ram_waddr_o,
    output logic [DW-1:0]          ram_wdata_o,
    output logic                   ram_wen_o,
    output logic [AW-1:0]          ram_raddr_o,
    output logic                   ram_rden_o,
    input  logic [DW-1:0]          ram_rdata_i,
    output logic [1:0]             bank_full_o,
    output logic                   ovf_err_o
);
    localparam int CW = AW - 1;   // word offset within a bank
    localparam int LW = AW;       // frame length / read count, 0..BANK_D

    typedef enum logic {W_FILL = 1'b0, W_DROP = 1'b1} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_RUN = 1'b1} rstate_e;

    // ---------------- write side ----------------
    wstate_e          wstate_q, wstate_d;
    logic             wbank_q;
    logic [CW-1:0]    wcnt_q;
    logic [LW-1:0]    len_q [2];
    logic             commit_q;
    logic             commit_bank_q;
    logic             ovf_q;
    logic             wen_q;
    logic [AW-1:0]    waddr_q;
    logic [DW-1:0]    wdata_q;
    logic             s_ready_c;

    logic             s_accept;
    logic             fill_acc;
    logic             wlast_word;
    logic             commit_now;
    logic             ovf_now;

    // ---------------- read side ----------------
    rstate_e          rstate_q, rstate_d;
    logic             rbank_q;
    logic [LW-1:0]    rcnt_q;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             inflight_q;
    logic             inflight_last_q;
    logic [LW-1:0]    rlen;
    logic             rd_done;
    logic             rd_credit;
    logic             rd_issue;
    logic [2:0]       occ;

    // ---------------- output FIFO ----------------
    logic [DW-1:0]    ob_data_q [2];
    logic             ob_last_q [2];
    logic             ob_wptr_q;
    logic             ob_rptr_q;
    logic [1:0]       ob_cnt_q;
    logic             pop;

    assign s_accept   = s_if.valid & s_ready_c;
    assign fill_acc   = s_accept & (wstate_q == W_FILL);
    assign wlast_word = (wcnt_q == CW'(BANK_D - 1));
    assign commit_now = fill_acc & (s_if.last | wlast_word);
    assign ovf_now    = fill_acc & wlast_word & ~s_if.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= W_FILL;
        end else begin
            wstate_q <= wstate_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_FILL:  if (ovf_now) wstate_d = W_DROP;
            W_DROP:  if (s_accept && s_if.last) wstate_d = W_FILL;
            default: wstate_d = W_FILL;
        endcase
    end

    // Held low during reset so the decoder never sees a handshake then.
    always_comb begin
        s_ready_c = 1'b0;
        if (rst_n) begin
            case (wstate_q)
                W_FILL:  s_ready_c = ~bank_full_q[wbank_q];
                W_DROP:  s_ready_c = 1'b1;
                default: s_ready_c = 1'b0;
            endcase
        end
    end

    assign s_if.ready = s_ready_c;

    // The RAM write lands one edge after accept; the bank is flagged full on
    // that same edge, so a read can never overtake its own write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q       <= 1'b0;
            wcnt_q        <= '0;
            len_q         <= '{default: '0};
            commit_q      <= 1'b0;
            commit_bank_q <= 1'b0;
            ovf_q         <= 1'b0;
            wen_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
        end else begin
            wen_q    <= fill_acc;
            commit_q <= commit_now;
            ovf_q    <= ovf_now;
            if (fill_acc) begin
                waddr_q <= {wbank_q, wcnt_q};
                wdata_q <= s_if.data;
            end
            if (commit_now) begin
                len_q[wbank_q] <= {1'b0, wcnt_q} + LW'(1);
                commit_bank_q  <= wbank_q;
                wbank_q        <= ~wbank_q;
                wcnt_q         <= '0;
            end else if (fill_acc) begin
                wcnt_q <= wcnt_q + CW'(1);
            end
        end
    end

    assign ram_wen_o   = wen_q;
    assign ram_waddr_o = waddr_q;
    assign ram_wdata_o = wdata_q;
    assign ovf_err_o   = ovf_q;

    // Read side. The same-cycle pop is counted in the credit so a word can be
    // issued every cycle while the consumer keeps draining.
    assign pop       = m_if.valid & m_if.ready;
    assign rlen      = len_q[rbank_q];
    assign rd_done   = (rstate_q == R_RUN) && (rcnt_q == rlen);
    assign occ       = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign rd_credit = (occ < 3'd2);

    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_done) bank_full_d[rbank_q] = 1'b0;
        if (commit_q) bank_full_d[commit_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q <= R_IDLE;
        end else begin
            rstate_q <= rstate_d;
        end
    end

    // Looking at the next-cycle flag lets the first read issue in the cycle
    // right after the RAM write.
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (bank_full_d[rbank_q]) rstate_d = R_RUN;
            R_RUN:   if (rd_done) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_issue    = 1'b0;
        ram_raddr_o = '0;
        if ((rstate_q == R_RUN) && !rd_done && rd_credit) begin
            rd_issue    = 1'b1;
            ram_raddr_o = {rbank_q, rcnt_q[CW-1:0]};
        end
    end

    assign ram_rden_o = rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank_q         <= 1'b0;
            rcnt_q          <= '0;
            bank_full_q     <= 2'b00;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            bank_full_q     <= bank_full_d;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (rcnt_q == rlen - LW'(1));
            if (rstate_q == R_IDLE) begin
                rcnt_q <= '0;
            end else if (rd_issue) begin
                rcnt_q <= rcnt_q + LW'(1);
            end
            if (rd_done) rbank_q <= ~rbank_q;
        end
    end

    assign bank_full_o = bank_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_data_q <= '{default: '0};
            ob_last_q <= '{default: 1'b0};
            ob_wptr_q <= 1'b0;
            ob_rptr_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                ob_data_q[ob_wptr_q] <= ram_rdata_i;
                ob_last_q[ob_wptr_q] <= inflight_last_q;
                ob_wptr_q            <= ~ob_wptr_q;
            end
            if (pop) ob_rptr_q <= ~ob_rptr_q;
            ob_cnt_q <= ob_cnt_q + 2'(inflight_q) - 2'(pop);
        end
    end

    assign m_if.valid = (ob_cnt_q != 2'd0);
    assign m_if.data  = ob_data_q[ob_rptr_q];
    assign m_if.last  = ob_last_q[ob_rptr_q];

endmodule
